// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Takes a byte stream [N][4*N little-endian data bytes][XOR checksum], writes each
// assembled word to imem through a registered write port, and keeps the core held
// until a load finishes with a matching checksum.
module imem_loader #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        words_loaded
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        word_idx_q, word_idx_d;
    logic [7:0]        chk_q, chk_d;
    logic [TW-1:0]     timeout_q, timeout_d;
    logic [7:0]        words_loaded_q, words_loaded_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer;
    logic [31:0]       word_next;

    assign xfer      = in_valid && in_ready_q;
    assign word_next = {in_data, word_q[31:8]};

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            word_idx_q     <= '0;
            chk_q          <= '0;
            timeout_q      <= '0;
            words_loaded_q <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            in_ready_q     <= 1'b0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            word_idx_q     <= word_idx_d;
            chk_q          <= chk_d;
            timeout_q      <= timeout_d;
            words_loaded_q <= words_loaded_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            in_ready_q     <= in_ready_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    // Next-state, datapath and output decode; outputs follow the next state so they
    // are valid one cycle after the deciding byte.
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        word_idx_d     = word_idx_q;
        chk_d          = chk_q;
        timeout_d      = timeout_q;
        words_loaded_d = words_loaded_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d        = S_COUNT;
                    words_loaded_d = '0;
                    chk_d          = '0;
                    timeout_d      = '0;
                    byte_cnt_d     = '0;
                    word_idx_d     = '0;
                    word_d         = '0;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    timeout_d = '0;
                    if (in_data == 8'd0 || in_data > 8'(DEPTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        n_d     = in_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    timeout_d  = '0;
                    word_d     = word_next;
                    chk_d      = chk_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d       = 1'b1;
                        mem_addr_d     = word_idx_q[ADDR_W-1:0];
                        mem_wdata_d    = word_next;
                        words_loaded_d = words_loaded_q + 8'd1;
                        word_idx_d     = word_idx_q + 8'd1;
                        if (word_idx_q == n_q - 8'd1) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    timeout_d = '0;
                    state_d   = (in_data == chk_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inactivity watchdog: only runs while a load is in progress.
        if ((state_q == S_COUNT || state_q == S_DATA || state_q == S_CHECK) && !xfer) begin
            timeout_d = timeout_q + 1'b1;
            if (timeout_q == TW'(TIMEOUT - 1)) begin
                state_d = S_ERROR;
            end
        end

        in_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHECK);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERROR);
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with TIMEOUT shortened to 16.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [7:0]  words_loaded;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Write log filled by the monitor; tests remember the count at their start.
    int unsigned wr_total = 0;
    logic [5:0]  wr_addr [0:255];
    logic [31:0] wr_data [0:255];

    logic [7:0] good_stream [0:9] = '{8'h02, 8'h93, 8'h02, 8'hA0, 8'h00,
                                      8'h13, 8'h00, 8'h00, 8'h00, 8'h22};

    imem_loader #(.DEPTH(64), .ADDR_W(6), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr[wr_total[7:0]] = mem_addr;
            wr_data[wr_total[7:0]] = mem_wdata;
            wr_total = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("send_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int unsigned gaps, input logic [7:0] last);
        for (int i = 0; i < 10; i++) begin
            if (gaps != 0) repeat ($urandom_range(0, 3)) tick();
            send_byte(i == 9 ? last : good_stream[i]);
        end
    endtask

    task automatic check_two_writes(input string tag, input int unsigned base);
        check({tag, "_nwr"}, wr_total - base, 32'd2);
        check({tag, "_a0"}, 32'(wr_addr[base[7:0]]), 32'd0);
        check({tag, "_d0"}, wr_data[base[7:0]], 32'h00A00293);
        check({tag, "_a1"}, 32'(wr_addr[8'(base + 1)]), 32'd1);
        check({tag, "_d1"}, wr_data[8'(base + 1)], 32'h00000013);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_wl"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int unsigned base;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // 1: good load
        base = wr_total;
        pulse_start();
        check("t1_ready_after_start", 32'(in_ready), 32'd1);
        send_stream(0, 8'h22);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_wl", 32'(words_loaded), 32'd2);
        check("t1_ready_done", 32'(in_ready), 32'd0);
        check_two_writes("t1", base);

        // 2: bad checksum, started from DONE
        base = wr_total;
        pulse_start();
        check("t2_hold_back", 32'(cpu_hold), 32'd1);
        check("t2_done_clr", 32'(done), 32'd0);
        check("t2_wl_clr", 32'(words_loaded), 32'd0);
        send_stream(0, 8'h23);
        check("t2_err", 32'(err), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        check("t2_wl", 32'(words_loaded), 32'd2);
        check_two_writes("t2", base);

        // 3: bad counts 0x41 and 0x00, then the upper bound 0x40 is accepted
        base = wr_total;
        pulse_start();
        check("t3_err_clr", 32'(err), 32'd0);
        send_byte(8'h41);
        check("t3_err_41", 32'(err), 32'd1);
        pulse_start();
        send_byte(8'h00);
        check("t3_err_00", 32'(err), 32'd1);
        check("t3_nwr", wr_total - base, 32'd0);
        pulse_start();
        send_byte(8'h40);
        check("t3_n64_err", 32'(err), 32'd0);
        check("t3_n64_ready", 32'(in_ready), 32'd1);

        // 4: timeout after a partial second word (also ends the N=64 load above)
        repeat (20) tick();
        check("t4_prev_timeout", 32'(err), 32'd1);
        base = wr_total;
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(good_stream[i]);
        send_byte(8'h93);
        repeat (15) tick();
        check("t4_err_at15", 32'(err), 32'd0);
        tick();
        check("t4_err_at16", 32'(err), 32'd1);
        check("t4_ready", 32'(in_ready), 32'd0);
        check("t4_nwr", wr_total - base, 32'd1);
        check("t4_d0", wr_data[base[7:0]], 32'h00A00293);
        check("t4_wl", 32'(words_loaded), 32'd1);

        // 5: reset in the middle of DATA, then a clean load
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(good_stream[i]);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        repeat (2) tick();
        check_reset_outputs("t5_held");
        rst_n = 1'b1;
        tick();
        base = wr_total;
        check("t5_no_stray_wr", wr_total - base, 32'd0);
        pulse_start();
        send_stream(0, 8'h22);
        check("t5_done", 32'(done), 32'd1);
        check_two_writes("t5", base);

        // 6: random gaps, with a start pulse in DATA that must be ignored
        base = wr_total;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_byte(good_stream[i]);
        end
        pulse_start();
        for (int i = 4; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_byte(good_stream[i]);
        end
        check("t6_done", 32'(done), 32'd1);
        check("t6_err", 32'(err), 32'd0);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_wl", 32'(words_loaded), 32'd2);
        repeat (3) tick();
        check_two_writes("t6", base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
